// File: rtl/pwm_pkg.sv
// Shared constants, frame field positions and FSM states for the
// SPI-to-PWM configuration loader.
package pwm_pkg;

    localparam int FRAME_BITS_DEF = 16;
    localparam int DUTY_MAX_DEF   = 100;
    localparam int DATA_W         = 12;
    localparam int CNT_W          = 5;

    localparam int RW_BIT  = 15;
    localparam int SEL_BIT = 14;
    localparam int RSV_HI  = 13;
    localparam int RSV_LO  = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    function automatic logic [DATA_W-1:0] clamp_duty(
        input logic [DATA_W-1:0] d,
        input logic [DATA_W-1:0] mx
    );
        return (d > mx) ? mx : d;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous input bit.
// Resets low so a chip select held low across reset never looks like a fresh fall.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pwm_spi_loader.sv
// SPI slave that receives 16-bit configuration frames and forwards
// period/duty writes to a PWM generator, with shadow readback on MISO.
module pwm_spi_loader
    import pwm_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter int DUTY_MAX   = DUTY_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [DATA_W-1:0] cfg_data,
    output logic              cfg_sel,
    output logic              cfg_wr_en,
    output logic              frame_err
);

    logic w_sclk;
    logic w_cs_n;
    logic w_mosi;

    sync2 u_sync_sclk (.clk(clk), .rst(rst), .i_d(spi_sclk), .o_q(w_sclk));
    sync2 u_sync_cs   (.clk(clk), .rst(rst), .i_d(spi_cs_n), .o_q(w_cs_n));
    sync2 u_sync_mosi (.clk(clk), .rst(rst), .i_d(spi_mosi), .o_q(w_mosi));

    logic r_sclk_d;
    logic r_cs_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_d <= 1'b0;
            r_cs_d   <= 1'b0;
        end else begin
            r_sclk_d <= w_sclk;
            r_cs_d   <= w_cs_n;
        end
    end

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_fall;
    logic w_cs_rise;

    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_cs_fall   = ~w_cs_n & r_cs_d;
    assign w_cs_rise   = w_cs_n & ~r_cs_d;

    state_t r_state;
    state_t w_state_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_cs_fall) w_state_nx = ST_SHIFT;
            ST_SHIFT: if (w_cs_rise) w_state_nx = ST_CHECK;
            ST_CHECK: w_state_nx = w_cs_fall ? ST_SHIFT : ST_IDLE;
            default:  w_state_nx = ST_IDLE;
        endcase
    end

    logic [FRAME_BITS-1:0] r_sh;
    logic [FRAME_BITS-1:0] r_tx;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_W-1:0]     r_sh_period;
    logic [DATA_W-1:0]     r_sh_duty;
    logic                  r_rd_sel;
    logic [DATA_W-1:0]     r_cfg_data;
    logic                  r_cfg_sel;
    logic                  r_wr_en;
    logic                  r_err;

    logic                  w_start;
    logic                  w_ok;
    logic [DATA_W-1:0]     w_val;
    logic [DATA_W-1:0]     w_shadow;

    // A CS fall seen during CHECK starts the next frame without a pass through IDLE.
    assign w_start  = w_cs_fall && (r_state == ST_IDLE || r_state == ST_CHECK);
    assign w_ok     = (r_cnt == CNT_W'(FRAME_BITS)) && (r_sh[RSV_HI:RSV_LO] == 2'b00);
    assign w_val    = r_sh[SEL_BIT] ? r_sh[DATA_W-1:0]
                    : clamp_duty(r_sh[DATA_W-1:0], DATA_W'(DUTY_MAX));
    assign w_shadow = r_rd_sel ? r_sh_period : r_sh_duty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh        <= '0;
            r_tx        <= '0;
            r_cnt       <= '0;
            r_sh_period <= '0;
            r_sh_duty   <= '0;
            r_rd_sel    <= 1'b0;
            r_cfg_data  <= '0;
            r_cfg_sel   <= 1'b0;
            r_wr_en     <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_err   <= 1'b0;
            if (w_start) begin
                r_sh  <= '0;
                r_cnt <= '0;
                r_tx  <= {{(FRAME_BITS-DATA_W){1'b0}}, w_shadow};
            end else if (r_state == ST_SHIFT) begin
                if (w_sclk_rise) begin
                    r_sh <= {r_sh[FRAME_BITS-2:0], w_mosi};
                    if (r_cnt != CNT_W'(FRAME_BITS + 1))
                        r_cnt <= r_cnt + 1'b1;
                end
                if (w_sclk_fall)
                    r_tx <= {r_tx[FRAME_BITS-2:0], 1'b0};
            end
            if (r_state == ST_CHECK) begin
                if (!w_ok) begin
                    r_err <= 1'b1;
                end else if (r_sh[RW_BIT]) begin
                    r_wr_en    <= 1'b1;
                    r_cfg_data <= w_val;
                    r_cfg_sel  <= r_sh[SEL_BIT];
                    if (r_sh[SEL_BIT]) r_sh_period <= w_val;
                    else               r_sh_duty   <= w_val;
                end else begin
                    r_rd_sel <= r_sh[SEL_BIT];
                end
            end
        end
    end

    assign spi_miso  = r_tx[FRAME_BITS-1];
    assign cfg_data  = r_cfg_data;
    assign cfg_sel   = r_cfg_sel;
    assign cfg_wr_en = r_wr_en;
    assign frame_err = r_err;

endmodule

// File: tb/tb_pwm_spi_loader.sv
// Randomized and directed bench for pwm_spi_loader against a frame-level
// model of accepted writes, rejected frames and shadow readback.
module tb_pwm_spi_loader;

    localparam int H    = 8;
    localparam int DMAX = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic [11:0] cfg_data;
    logic        cfg_sel;
    logic        cfg_wr_en;
    logic        frame_err;

    pwm_spi_loader dut (
        .clk(clk), .rst(rst),
        .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_mosi(mosi), .spi_miso(miso),
        .cfg_data(cfg_data), .cfg_sel(cfg_sel),
        .cfg_wr_en(cfg_wr_en), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;
    int cs_rise_cyc = 0;
    int last_wr_cyc = -1;
    int last_err_cyc = -1;

    logic [11:0] m_per = 0;
    logic [11:0] m_duty = 0;
    logic        m_rd_sel = 0;
    logic [12:0] hold = 0;
    logic [12:0] exp_wr[$];
    int          exp_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (cfg_wr_en) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_wr", 32'(cfg_wr_en), 32'd0);
                end else begin
                    hold = exp_wr.pop_front();
                    chk("wr_value", 32'({cfg_sel, cfg_data}), 32'(hold));
                    last_wr_cyc = cyc;
                end
            end else begin
                chk("cfg_hold", 32'({cfg_sel, cfg_data}), 32'(hold));
            end
            if (frame_err) begin
                chk("unexpected_err", 32'(exp_err > 0), 32'd1);
                if (exp_err > 0) exp_err--;
                last_err_cyc = cyc;
            end
        end
    end

    task automatic wait_h();
        repeat (H) @(negedge clk);
    endtask

    task automatic frame(input int nbits, input logic [15:0] val,
                         input bit coinc, output logic [15:0] rx);
        logic [15:0] exp_miso;
        logic [11:0] d;
        bit acc;
        exp_miso = {4'b0, m_rd_sel ? m_per : m_duty};
        acc = (nbits == 16) && (val[13:12] == 2'b00);
        d = val[11:0];
        if (!val[14] && d > 12'(DMAX)) d = 12'(DMAX);
        if (!acc) exp_err++;
        else if (val[15]) exp_wr.push_back({val[14], d});
        rx = '0;
        cs_n = 1'b0;
        wait_h();
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 16) ? val[15-i] : 1'b0;
            wait_h();
            if (i < 16) rx[15-i] = miso;
            sclk = 1'b1;
            if (coinc && i == nbits - 1) begin
                cs_n = 1'b1;
                cs_rise_cyc = cyc;
            end
            wait_h();
            sclk = 1'b0;
        end
        if (!coinc) begin
            wait_h();
            cs_n = 1'b1;
            cs_rise_cyc = cyc;
        end
        repeat (14) @(negedge clk);
        chk("wr_missing", 32'(exp_wr.size()), 32'd0);
        chk("err_missing", 32'(exp_err), 32'd0);
        if (nbits >= 16) chk("miso_readback", 32'(rx), 32'(exp_miso));
        if (acc) begin
            if (!val[15]) m_rd_sel = val[14];
            else if (val[14]) m_per = d;
            else m_duty = d;
        end
    endtask

    logic [15:0] rx;
    logic [15:0] v;
    int nb;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(cfg_data), 32'd0);
        chk("rst_sel", 32'(cfg_sel), 32'd0);
        chk("rst_wr", 32'(cfg_wr_en), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        chk("rst_miso", 32'(miso), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        frame(16, 16'hC3E8, 0, rx);
        chk("period_latency", 32'(last_wr_cyc - cs_rise_cyc), 32'd4);
        chk("period_data", 32'(cfg_data), 32'h3E8);
        chk("period_sel", 32'(cfg_sel), 32'd1);

        frame(16, 16'h8096, 0, rx);
        chk("duty_clamped", 32'(cfg_data), 32'd100);
        chk("duty_sel", 32'(cfg_sel), 32'd0);

        frame(9, 16'h8123, 0, rx);
        chk("short_err_latency", 32'(last_err_cyc - cs_rise_cyc), 32'd4);
        chk("short_keeps_data", 32'(cfg_data), 32'd100);

        frame(16, 16'h9005, 0, rx);
        frame(17, 16'h8005, 0, rx);

        frame(16, 16'h4000, 0, rx);
        frame(16, 16'h0000, 0, rx);
        chk("readback_period", 32'(rx), 32'h03E8);

        frame(16, 16'h8032, 1, rx);
        chk("coincident_edge", 32'(cfg_data), 32'd50);

        cs_n = 1'b0;
        wait_h();
        for (int i = 0; i < 8; i++) begin
            mosi = 1'b1;
            wait_h();
            sclk = 1'b1;
            wait_h();
            sclk = 1'b0;
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_data", 32'(cfg_data), 32'd0);
        chk("async_rst_sel", 32'(cfg_sel), 32'd0);
        chk("async_rst_miso", 32'(miso), 32'd0);
        chk("async_rst_wr", 32'(cfg_wr_en), 32'd0);
        m_per = 0;
        m_duty = 0;
        m_rd_sel = 0;
        hold = 0;
        exp_wr.delete();
        exp_err = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        cs_n = 1'b1;
        repeat (20) @(negedge clk);
        frame(16, 16'h8032, 0, rx);
        chk("post_rst_write", 32'(cfg_data), 32'd50);

        for (int k = 0; k < 40; k++) begin
            v = 16'($urandom);
            if ($urandom_range(0, 3) != 0) v[13:12] = 2'b00;
            if ($urandom_range(0, 1) == 0) v[11:0] = 12'($urandom_range(0, 200));
            nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 20)) : 16;
            frame(nb, v, 0, rx);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/pwm_spi_loader.md
PWM_SPI_LOADER -- requirements
Module: pwm_spi_loader

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 16, meaning SPI frame length in bits.
REQ-002 SHALL have parameter DUTY_MAX, default 100, meaning largest duty value forwarded, in percent.
REQ-003 SHALL have port clk  input  1  single system clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port spi_sclk  input  1  SPI clock, mode 0, asynchronous to clk.
REQ-006 SHALL have port spi_cs_n  input  1  SPI chip select, active low, asynchronous.
REQ-007 SHALL have port spi_mosi  input  1  SPI data in, MSB first.
REQ-008 SHALL have port spi_miso  output  1  SPI readback data, MSB first.
REQ-009 SHALL have port cfg_data  output  12  value for the PWM generator data input.
REQ-010 SHALL have port cfg_sel  output  1  1 = period, 0 = duty; drives the PWM generator select.
REQ-011 SHALL have port cfg_wr_en  output  1  one-clk write strobe to the PWM generator.
REQ-012 SHALL have port frame_err  output  1  one-clk pulse on a rejected frame.

Function
REQ-013 SHALL pass spi_sclk, spi_cs_n and spi_mosi through two-flop synchronizers before use; spi_sclk max = clk/8.
REQ-014 SHALL detect the SCLK rising edge, CS falling edge and CS rising edge from synchronized signals, one clk each.
REQ-015 SHALL use the frame layout [15]=rw (1 write, 0 read), [14]=sel, [13:12]=reserved (must be 0), [11:0]=data.
REQ-016 SHALL implement the FSM IDLE -> SHIFT on CS fall; SHIFT -> CHECK on CS rise; CHECK -> IDLE after one clk.
REQ-017 SHALL, in SHIFT, shift synchronized MOSI into a 16-bit register on each SCLK rise and increment a 5-bit bit counter that saturates at 17.
REQ-018 SHALL, in CHECK, accept the frame only if bit count == 16 and reserved bits == 0; otherwise pulse frame_err and discard it.
REQ-019 SHALL, for an accepted write, drive cfg_wr_en high for exactly one clk in the cycle after CHECK, with cfg_data/cfg_sel valid in that same cycle.
REQ-020 SHALL clamp duty writes (sel=0) with data > DUTY_MAX to DUTY_MAX; period writes pass unmodified, including 0.
REQ-021 SHALL keep shadow_period and shadow_duty (12 bits each), updated in the same cycle as cfg_wr_en with the post-clamp value.
REQ-022 SHALL make an accepted read frame issue no write and only latch rd_sel = frame[14].
REQ-023 SHALL shift out on spi_miso during each frame {4'b0, shadow register chosen by rd_sel}, MSB first, updating after each synchronized SCLK fall.
REQ-024 SHALL keep cfg_data and cfg_sel holding their last written values between strobes.
REQ-025 SHALL, when an SCLK rise and a CS rise are detected in the same clk, count the bit before evaluating the frame.
REQ-026 SHALL, on a CS fall while in CHECK, enter SHIFT after CHECK completes; no frame is lost.
REQ-027 SHALL ignore SCLK edges seen in IDLE.

Reset
REQ-028 SHALL, on rst assertion, immediately set FSM=IDLE, shift register, bit counter, shadows and rd_sel to 0, and outputs cfg_data=0, cfg_sel=0, cfg_wr_en=0, frame_err=0, spi_miso=0.
REQ-029 SHALL discard any partial frame on reset mid-frame and issue no write.
REQ-030 SHALL, after rst release with CS already low, wait for a fresh CS fall before shifting.

Structure
REQ-031 SHALL take FRAME_BITS, DUTY_MAX, the field bit positions and the FSM state enum from shared package pwm_pkg.
REQ-032 SHALL implement the two-flop synchronizer as sub-module sync2, instantiated three times.

Verification
REQ-033 SHALL cover: write frame 0xC3E8 (period 1000) -> one cfg_wr_en pulse, cfg_sel=1, cfg_data=0x3E8, 1 clk after CHECK.
REQ-034 SHALL cover: write frame 0x8096 (duty 150) -> cfg_sel=0, cfg_data=100 (clamped).
REQ-035 SHALL cover: CS raised after 9 SCLK edges -> frame_err pulse, no cfg_wr_en, outputs unchanged.
REQ-036 SHALL cover: frame 0x9005 (reserved bit set) -> frame_err, no write; then 17-edge frame -> frame_err.
REQ-037 SHALL cover: period write 0x3E8, then read frame 0x4000, then any frame -> MISO returns 0x03E8.
REQ-038 SHALL cover: rst asserted at bit 8 of a write frame -> all outputs 0 asynchronously, no write; next complete frame is accepted normally.
